// File: rtl/sequential_divider_16_pkg.sv
// sequential_divider_16_pkg: widths and FSM encoding shared by the restoring divider.
package sequential_divider_16_pkg;
    localparam int DIV_N = 16;
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
    localparam int CNT_W = cnt_w(DIV_N);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sequential_divider_16_if.sv
// sequential_divider_16_if: start/busy/done handshake plus operands and results.
interface sequential_divider_16_if
    import sequential_divider_16_pkg::*;
#(
    parameter int N = DIV_N
);
    logic           iStart;
    logic [2*N-1:0] iDividend;
    logic [N-1:0]   iDivisor;
    logic           oBusy;
    logic           oDone;
    logic           oError;
    logic [N-1:0]   oQuotient;
    logic [N-1:0]   oRemainder;
    modport master (output iStart, iDividend, iDivisor, input oBusy, oDone, oError, oQuotient, oRemainder);
    modport slave (input iStart, iDividend, iDivisor, output oBusy, oDone, oError, oQuotient, oRemainder);
endinterface

// File: rtl/sequential_divider_16_divide_step.sv
// divide_step: one restoring step; subtract the divisor when it fits, emit the quotient bit.
module divide_step #(
    parameter int N = 16
) (
    input  logic [N:0]   t_i,
    input  logic [N-1:0] d_i,
    output logic [N:0]   p_o,
    output logic         q_o
);
    always_comb begin
        q_o = t_i >= {1'b0, d_i};
        p_o = q_o ? t_i - {1'b0, d_i} : t_i;
    end
endmodule

// File: rtl/sequential_divider_16.sv
// sequential_divider_16: 2N/N restoring divider, one quotient bit per clock.
module sequential_divider_16
    import sequential_divider_16_pkg::*;
#(
    parameter int N = DIV_N
) (
    input logic                   Clock,
    input logic                   Reset,
    sequential_divider_16_if.slave bus
);
    localparam int CW = cnt_w(N);
    state_t          state_q;
    logic [N:0]      p_q, p_d;
    logic [N-1:0]    q_q, q_d, d_q, quo_q, rem_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, err_q, bit_d, bad;
    divide_step #(.N(N)) u_step (
        .t_i({p_q[N-1:0], q_q[N-1]}),
        .d_i(d_q),
        .p_o(p_d),
        .q_o(bit_d)
    );
    always_comb begin
        q_d = {q_q[N-2:0], bit_d};
        bad = (bus.iDivisor == '0) || (bus.iDividend[2*N-1:N] >= bus.iDivisor);
    end
    // A valid request is also taken in DONE so held iStart streams every N+1 cycles;
    // error requests wait for IDLE so oDone never pulses twice in a row.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (bus.iStart && !bad) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        p_q     <= {1'b0, bus.iDividend[2*N-1:N]};
                        q_q     <= bus.iDividend[N-1:0];
                        d_q     <= bus.iDivisor;
                        cnt_q   <= '0;
                    end else if (bus.iStart && state_q == IDLE) begin
                        state_q <= DONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        quo_q   <= '1;
                        rem_q   <= '0;
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        quo_q   <= q_d;
                        rem_q   <= p_d[N-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // The partial remainder stays below the divisor between steps, so its top bit is always clear.
    assert property (@(posedge Clock) disable iff (Reset) p_q[N] == 1'b0);
    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;
    assign bus.oError     = err_q;
    assign bus.oQuotient  = quo_q;
    assign bus.oRemainder = rem_q;
endmodule

// File: tb/tb_sequential_divider_16.sv
// tb_sequential_divider_16: scoreboard bench for the restoring divider.
module tb_sequential_divider_16;
    import sequential_divider_16_pkg::*;
    localparam int N = DIV_N;
    typedef struct {
        int           a;
        int           lat;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         e;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic prev_done = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    sequential_divider_16_if #(.N(N)) bus ();
    sequential_divider_16 #(.N(N)) dut (.Clock(clk), .Reset(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.oDone) begin
            check("no_dbl_done", {31'd0, prev_done}, 0);
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("latency", cyc - e.a, e.lat);
                check("quotient", {16'd0, bus.oQuotient}, {16'd0, e.q});
                check("remainder", {16'd0, bus.oRemainder}, {16'd0, e.r});
                check("error", {31'd0, bus.oError}, {31'd0, e.e});
            end
        end else if (!rst) check("err_without_done", {31'd0, bus.oError}, 0);
        prev_done = bus.oDone;
    end
    task automatic start_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                            input logic [N-1:0] q, input logic [N-1:0] r, input logic e);
        @(negedge clk);
        bus.iStart    = 1'b1;
        bus.iDividend = dd;
        bus.iDivisor  = dv;
        sb.push_back('{cyc + 1, e ? 0 : N, q, r, e});
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 40 && bus.oBusy; i++) @(negedge clk);
        check("idle_timeout", {31'd0, bus.oBusy}, 0);
        check("sb_empty", sb.size(), 0);
    endtask
    task automatic run(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                       input logic [N-1:0] q, input logic [N-1:0] r, input logic e);
        start_op(dd, dv, q, r, e);
        wait_idle();
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, bus.oBusy}, 0);
        check({tag, "_done"}, {31'd0, bus.oDone}, 0);
        check({tag, "_err"}, {31'd0, bus.oError}, 0);
        check({tag, "_quo"}, {16'd0, bus.oQuotient}, 0);
        check({tag, "_rem"}, {16'd0, bus.oRemainder}, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [N-1:0] d, q, r;
        int seen;
        bus.iStart = 1'b0;
        bus.iDividend = '0;
        bus.iDivisor = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        run(32'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
        run(32'hFFFEFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
        run(32'd1234, 16'd0, 16'hFFFF, 16'h0000, 1'b1);
        run(32'h00010000, 16'd1, 16'hFFFF, 16'h0000, 1'b1);
        run(32'h0000FFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0);
        // A second request mid-operation must be ignored.
        start_op(32'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        bus.iStart = 1'b1;
        bus.iDividend = 32'd5000;
        bus.iDivisor = 16'd3;
        @(negedge clk);
        bus.iStart = 1'b0;
        wait_idle();
        // Reset mid-operation: outputs clear and no oDone follows.
        run(32'd50000, 16'd3, 16'd16666, 16'd2, 1'b0);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iDividend = 32'd100;
        bus.iDivisor = 16'd7;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        repeat (20) @(negedge clk);
        check("midreset_idle", {31'd0, bus.oBusy}, 0);
        run(32'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        for (int i = 0; i < 200; i++) begin
            d = 16'($urandom_range(1, 65535));
            q = 16'($urandom);
            r = 16'($urandom_range(0, int'(d) - 1));
            run(32'(q) * 32'(d) + 32'(r), d, q, r, 1'b0);
        end
        // Held iStart: back-to-back operations every N+1 cycles.
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iDividend = 32'd100;
        bus.iDivisor = 16'd7;
        for (int k = 0; k < 3; k++) sb.push_back('{cyc + 1 + k * (N + 1), N, 16'd14, 16'd2, 1'b0});
        seen = 0;
        for (int i = 0; i < 80 && seen < 3; i++) begin
            @(negedge clk);
            if (seen > 0) check("hold_quo", {16'd0, bus.oQuotient}, 32'd14);
            if (bus.oDone) seen++;
        end
        bus.iStart = 1'b0;
        wait_idle();
        check("b2b_count", seen, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
